// File: rtl/enc_stage6_scheduler.sv
// Stage 6 codeword scheduler: merges run/regular encoder outputs into one in-order FIFO feeding
// Stage 7, throttles the encoders, and closes each frame with a drain and packer flush handshake.
module enc_stage6_scheduler #(
  parameter int unsigned encodedpixel_width  = 32,
  parameter int unsigned encodedlength_width = 6,
  parameter int unsigned DEPTH               = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_frame,
  input  logic                           run_valid,
  input  logic [encodedpixel_width-1:0]  run_word,
  input  logic [encodedlength_width-1:0] run_len,
  input  logic                           reg_valid,
  input  logic [encodedpixel_width-1:0]  reg_word,
  input  logic [encodedlength_width-1:0] reg_len,
  input  logic                           reg_eof,
  output logic                           stall_6,
  output logic                           out_valid,
  output logic [encodedpixel_width-1:0]  out_word,
  output logic [encodedlength_width-1:0] out_len,
  output logic                           out_eof,
  input  logic                           pack_ready,
  output logic                           flush_req,
  input  logic                           flush_ack,
  output logic                           frame_done,
  output logic                           proto_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] StallLvl = CW'(DEPTH - 2);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StFlush  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, reg_slot;
  logic [CW-1:0] count_q, count_d;
  logic          flush_req_q, frame_done_q, proto_err_q;

  logic [encodedpixel_width-1:0]  word_mem [DEPTH];
  logic [encodedlength_width-1:0] len_mem  [DEPTH];
  logic [DEPTH-1:0]               eof_mem;

  logic accept, push_run, push_reg, eof_push, pop, dropped, head_eof;

  always_comb begin
    stall_6  = (count_q >= StallLvl) || (state_q != StActive);
    accept   = (state_q == StActive) && !stall_6;
    push_run = accept && run_valid && (run_len != '0);
    // A zero-length EOF marker must still reach the packer to close the frame.
    push_reg = accept && reg_valid && ((reg_len != '0) || reg_eof);
    eof_push = push_reg && reg_eof;
    dropped  = (run_valid || reg_valid) && !accept;
    reg_slot = wr_ptr_q + PW'(push_run);

    out_valid = (count_q != '0);
    head_eof  = eof_mem[rd_ptr_q];
    out_word  = out_valid ? word_mem[rd_ptr_q] : '0;
    out_len   = out_valid ? len_mem[rd_ptr_q] : '0;
    out_eof   = out_valid && head_eof;
    pop       = out_valid && pack_ready;
    count_d   = count_q + CW'(push_run) + CW'(push_reg) - CW'(pop);

    flush_req  = flush_req_q;
    frame_done = frame_done_q;
    proto_err  = proto_err_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_frame) state_d = StActive;
      StActive: if (eof_push) state_d = StDrain;
      StDrain:  if (pop && head_eof) state_d = StFlush;
      StFlush:  if (flush_ack) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      flush_req_q  <= 1'b0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_q + PW'(pop);
      wr_ptr_q     <= wr_ptr_q + PW'(push_run) + PW'(push_reg);
      count_q      <= count_d;
      flush_req_q  <= (state_d == StFlush);
      frame_done_q <= (state_q == StFlush) && flush_ack;
      if ((state_q == StIdle) && start_frame) begin
        proto_err_q <= 1'b0;
      end else if (dropped) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Run entry takes the first free slot so it precedes a same-cycle regular entry.
  always_ff @(posedge clk) begin
    if (push_run) begin
      word_mem[wr_ptr_q] <= run_word;
      len_mem[wr_ptr_q]  <= run_len;
      eof_mem[wr_ptr_q]  <= 1'b0;
    end
    if (push_reg) begin
      word_mem[reg_slot] <= reg_word;
      len_mem[reg_slot]  <= reg_len;
      eof_mem[reg_slot]  <= reg_eof;
    end
  end

endmodule
